// File: rtl/sim_step_scheduler_if.sv
// Handshake/status bundle between the step scheduler and the simulation array.
interface sim_step_scheduler_if #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned NODES = 5,
  parameter int unsigned CORES = 4
) ();
  localparam int unsigned AW = $clog2(NODES);

  logic             start;
  logic [WIDTH-1:0] num_steps;
  logic             pause;
  logic [CORES-1:0] exch_ack;
  logic             busy;
  logic             done;
  logic [1:0]       phase;
  logic             verlet_en;
  logic             cnst_en;
  logic             exch_req;
  logic [NODES-1:0] node_onehot;
  logic [AW-1:0]    node_addr;
  logic [WIDTH-1:0] cnst_iter;
  logic [WIDTH-1:0] step_count;

  modport master (
    output start, num_steps, pause, exch_ack,
    input  busy, done, phase, verlet_en, cnst_en, exch_req,
           node_onehot, node_addr, cnst_iter, step_count
  );

  modport slave (
    input  start, num_steps, pause, exch_ack,
    output busy, done, phase, verlet_en, cnst_en, exch_req,
           node_onehot, node_addr, cnst_iter, step_count
  );
endinterface

// File: rtl/sim_step_scheduler.sv
// Step sequencer: Verlet pass, CNST_ITERS constraint passes, then exchange handshake.
// Optional freeze on pause when SIM_SCHED_PAUSE_EN is defined.
module sim_step_scheduler #(
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned NODES      = 5,
  parameter int unsigned CORES      = 4,
  parameter int unsigned CNST_ITERS = 4
) (
  input logic                 clk,
  input logic                 reset,
  sim_step_scheduler_if.slave bus
);
  localparam int unsigned AW = $clog2(NODES);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    VERLET = 2'd1,
    CNST   = 2'd2,
    EXCH   = 2'd3
  } state_t;

  state_t           state_q, state_n;
  logic [NODES-1:0] onehot_q, onehot_n;
  logic [AW-1:0]    addr_q, addr_n;
  logic [WIDTH-1:0] iter_q, iter_n;
  logic [WIDTH-1:0] step_q, step_n;
  logic [WIDTH-1:0] nsteps_q, nsteps_n;
  logic             done_q, done_n;
  logic             busy_q, busy_n;
  logic             verlet_q, verlet_n;
  logic             cnst_q, cnst_n;
  logic             exch_q, exch_n;

  logic             last_slot;
  logic             last_pass;
  logic             ack_all;
  logic [WIDTH-1:0] step_inc;

  assign last_slot = (addr_q == AW'(NODES - 1));
  assign last_pass = (iter_q == WIDTH'(CNST_ITERS - 1));
  assign ack_all   = &bus.exch_ack;
  assign step_inc  = step_q + WIDTH'(1);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      onehot_q <= '0;
      addr_q   <= '0;
      iter_q   <= '0;
      step_q   <= '0;
      nsteps_q <= '0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
      verlet_q <= 1'b0;
      cnst_q   <= 1'b0;
      exch_q   <= 1'b0;
    end else begin
      state_q  <= state_n;
      onehot_q <= onehot_n;
      addr_q   <= addr_n;
      iter_q   <= iter_n;
      step_q   <= step_n;
      nsteps_q <= nsteps_n;
      done_q   <= done_n;
      busy_q   <= busy_n;
      verlet_q <= verlet_n;
      cnst_q   <= cnst_n;
      exch_q   <= exch_n;
    end
  end

  always_comb begin
    state_n  = state_q;
    onehot_n = onehot_q;
    addr_n   = addr_q;
    iter_n   = iter_q;
    step_n   = step_q;
    nsteps_n = nsteps_q;
    done_n   = 1'b0;

    unique case (state_q)
      IDLE: begin
        onehot_n = '0;
        addr_n   = '0;
        if (bus.start) begin
          if (bus.num_steps != '0) begin
            state_n  = VERLET;
            nsteps_n = bus.num_steps;
            step_n   = '0;
            onehot_n = NODES'(1);
          end else begin
            done_n = 1'b1;
          end
        end
      end
      VERLET: begin
        if (last_slot) begin
          state_n  = CNST;
          onehot_n = NODES'(1);
          addr_n   = '0;
          iter_n   = '0;
        end else begin
          onehot_n = onehot_q << 1;
          addr_n   = addr_q + AW'(1);
        end
      end
      CNST: begin
        if (!last_slot) begin
          onehot_n = onehot_q << 1;
          addr_n   = addr_q + AW'(1);
        end else if (!last_pass) begin
          onehot_n = NODES'(1);
          addr_n   = '0;
          iter_n   = iter_q + WIDTH'(1);
        end else begin
          state_n  = EXCH;
          onehot_n = '0;
          addr_n   = '0;
          iter_n   = '0;
        end
      end
      EXCH: begin
        // exch_req holds until every core has acknowledged
        if (ack_all) begin
          step_n = step_inc;
          if (step_inc == nsteps_q) begin
            state_n = IDLE;
            done_n  = 1'b1;
          end else begin
            state_n  = VERLET;
            onehot_n = NODES'(1);
            addr_n   = '0;
          end
        end
      end
      default: state_n = IDLE;
    endcase

`ifdef SIM_SCHED_PAUSE_EN
    // Freeze everything except the self-clearing done pulse
    if (bus.pause) begin
      state_n  = state_q;
      onehot_n = onehot_q;
      addr_n   = addr_q;
      iter_n   = iter_q;
      step_n   = step_q;
      nsteps_n = nsteps_q;
      done_n   = 1'b0;
    end
`endif

    busy_n   = (state_n != IDLE);
    verlet_n = (state_n == VERLET);
    cnst_n   = (state_n == CNST);
    exch_n   = (state_n == EXCH);
  end

  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.phase       = state_q;
  assign bus.node_onehot = onehot_q;
  assign bus.node_addr   = addr_q;
  assign bus.cnst_iter   = iter_q;
  assign bus.step_count  = step_q;

`ifdef SIM_SCHED_PAUSE_EN
  assign bus.verlet_en = verlet_q & ~bus.pause;
  assign bus.cnst_en   = cnst_q & ~bus.pause;
  assign bus.exch_req  = exch_q & ~bus.pause;
`else
  logic unused_pause;
  assign unused_pause  = bus.pause;
  assign bus.verlet_en = verlet_q;
  assign bus.cnst_en   = cnst_q;
  assign bus.exch_req  = exch_q;
`endif
endmodule

// File: tb/tb_sim_step_scheduler.sv
// Randomized bench for sim_step_scheduler against a position-counter model of a step.
module tb_sim_step_scheduler;
  localparam int unsigned W     = 32;
  localparam int unsigned NODES = 5;
  localparam int unsigned CORES = 4;
  localparam int unsigned CI    = 2;
  localparam int unsigned P     = NODES * (1 + CI);

  logic clk;
  logic reset;

  sim_step_scheduler_if #(.WIDTH(W), .NODES(NODES), .CORES(CORES)) bus ();

  sim_step_scheduler #(.WIDTH(W), .NODES(NODES), .CORES(CORES), .CNST_ITERS(CI)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Model: a run is a position 0..P within a step (P = exchange) plus a step counter
  bit          m_active = 1'b0;
  int unsigned m_pos    = 0;
  bit [W-1:0]  m_step   = '0;
  bit [W-1:0]  m_nsteps = '0;
  bit          m_done   = 1'b0;
  int          cyc      = 0;
  int          m_t0     = 0;

  logic pause_eff;
`ifdef SIM_SCHED_PAUSE_EN
  assign pause_eff = bus.pause;
`else
  assign pause_eff = 1'b0;
`endif

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (reset) begin
      m_active <= 1'b0;
      m_pos    <= 0;
      m_step   <= '0;
      m_done   <= 1'b0;
    end else if (pause_eff) begin
      m_done <= 1'b0;
    end else begin
      m_done <= 1'b0;
      if (!m_active) begin
        if (bus.start) begin
          m_t0 <= cyc + 1;
          if (bus.num_steps != '0) begin
            m_active <= 1'b1;
            m_pos    <= 0;
            m_step   <= '0;
            m_nsteps <= bus.num_steps;
          end else begin
            m_done <= 1'b1;
          end
        end
      end else if (m_pos < P) begin
        m_pos <= m_pos + 1;
      end else if (bus.exch_ack == {CORES{1'b1}}) begin
        m_step <= m_step + 1;
        if (m_step + 1 == m_nsteps) begin
          m_active <= 1'b0;
          m_done   <= 1'b1;
        end else begin
          m_pos <= 0;
        end
      end
    end
  end

  int checks = 0;
  int errors = 0;
  int seen_t0 = -1;
  int first_exch_rel = -1;
  int last_done_rel = -1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", name, cyc, act, exp);
    end
  endtask

  task automatic compare();
    logic [1:0]       ep;
    int unsigned      a;
    logic [NODES-1:0] eoh;
    logic [W-1:0]     eit;
    if (!m_active)         ep = 2'd0;
    else if (m_pos < NODES) ep = 2'd1;
    else if (m_pos < P)     ep = 2'd2;
    else                    ep = 2'd3;
    a   = (m_active && m_pos < P) ? (m_pos % NODES) : 0;
    eoh = (m_active && m_pos < P) ? NODES'(1 << a) : '0;
    eit = (ep == 2'd2) ? W'((m_pos - NODES) / NODES) : '0;
    chk("phase", 64'(bus.phase), 64'(ep));
    chk("busy", 64'(bus.busy), 64'(m_active));
    chk("done", 64'(bus.done), 64'(m_done));
    chk("verlet_en", 64'(bus.verlet_en), 64'(ep == 2'd1 && !pause_eff));
    chk("cnst_en", 64'(bus.cnst_en), 64'(ep == 2'd2 && !pause_eff));
    chk("exch_req", 64'(bus.exch_req), 64'(ep == 2'd3 && !pause_eff));
    chk("node_onehot", 64'(bus.node_onehot), 64'(eoh));
    chk("node_addr", 64'(bus.node_addr), 64'(a));
    chk("cnst_iter", 64'(bus.cnst_iter), 64'(eit));
    chk("step_count", 64'(bus.step_count), 64'(m_step));
    if (m_t0 != seen_t0) begin
      seen_t0        = m_t0;
      first_exch_rel = -1;
      last_done_rel  = -1;
    end
    if (bus.exch_req && first_exch_rel < 0) first_exch_rel = cyc - m_t0 + 1;
    if (bus.done) last_done_rel = cyc - m_t0 + 1;
  endtask

  task automatic tick();
    @(negedge clk);
    compare();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [W-1:0] n);
    bus.start     = 1'b1;
    bus.num_steps = n;
    tick();
    bus.start     = 1'b0;
    bus.num_steps = W'($urandom);
  endtask

  task automatic wait_idle(input int budget);
    int k;
    k = 0;
    while (m_active && k < budget) begin
      tick();
      k++;
    end
    checks++;
    if (m_active) begin
      errors++;
      $display("FAIL run_timeout cyc=%0d got=busy exp=idle", cyc);
    end
    tick();
  endtask

  initial begin
    int rel;
    int xcnt;
    reset         = 1'b1;
    bus.start     = 1'b0;
    bus.num_steps = '0;
    bus.pause     = 1'b0;
    bus.exch_ack  = {CORES{1'b1}};
    @(posedge clk);
    #1;
    repeat (3) tick();
    chk("rst_phase", 64'(bus.phase), 64'd0);
    chk("rst_busy", 64'(bus.busy), 64'd0);
    reset = 1'b0;
    tick();

    // Single step
    do_start(W'(1));
    wait_idle(100);
    chk("single_exch_cycle", 64'(first_exch_rel), 64'd16);
    chk("single_done_cycle", 64'(last_done_rel), 64'd17);
    chk("single_step_count", 64'(bus.step_count), 64'd1);

    // Three steps, each exchange acked on its 4th cycle, stray starts ignored
    do_start(W'(3));
    xcnt = 0;
    for (int k = 0; k < 300 && m_active; k++) begin
      if (m_active && m_pos == P) begin
        bus.exch_ack = (xcnt < 3) ? 4'h7 : 4'hF;
        xcnt++;
      end else begin
        xcnt = 0;
        bus.exch_ack = 4'($urandom);
      end
      bus.start     = ($urandom_range(0, 3) == 0);
      bus.num_steps = W'($urandom_range(1, 9));
      tick();
    end
    bus.start    = 1'b0;
    bus.exch_ack = 4'hF;
    wait_idle(10);
    chk("multi_done_cycle", 64'(last_done_rel), 64'd58);
    chk("multi_step_count", 64'(bus.step_count), 64'd3);

    // Zero steps
    do_start(W'(0));
    tick();
    chk("zero_done_cycle", 64'(last_done_rel), 64'd1);
    tick();

    // Reset in the middle of CNST, then a clean run
    do_start(W'(2));
    rel = 1;
    while (rel < 9) begin
      tick();
      rel++;
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("midrst_busy", 64'(bus.busy), 64'd0);
    chk("midrst_addr", 64'(bus.node_addr), 64'd0);
    repeat (3) tick();
    chk("midrst_no_done", 64'(last_done_rel), 64'hFFFF_FFFF_FFFF_FFFF);
    do_start(W'(1));
    wait_idle(100);
    chk("post_rst_done_cycle", 64'(last_done_rel), 64'd17);

`ifdef SIM_SCHED_PAUSE_EN
    // Pause over cycles 3..6 delays completion by four cycles
    do_start(W'(1));
    for (int k = 0; k < 100 && m_active; k++) begin
      rel = cyc - m_t0 + 1;
      bus.pause = (rel >= 3 && rel <= 6);
      tick();
    end
    bus.pause = 1'b0;
    wait_idle(10);
    chk("pause_done_cycle", 64'(last_done_rel), 64'd21);
`endif

    // Random runs: random acks, pauses, stray starts
    for (int r = 0; r < 8; r++) begin
      bus.pause = 1'b0;
      do_start(W'($urandom_range(0, 3)));
      for (int k = 0; k < 1500 && m_active; k++) begin
        bus.exch_ack  = ($urandom_range(0, 1) == 1) ? 4'hF : 4'($urandom);
        bus.pause     = ($urandom_range(0, 4) == 0);
        bus.start     = ($urandom_range(0, 5) == 0);
        bus.num_steps = W'($urandom);
        tick();
      end
      bus.start = 1'b0;
      bus.pause = 1'b0;
      bus.exch_ack = 4'hF;
      wait_idle(20);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/sim_step_scheduler.md
# sim_step_scheduler

Top-level sequencer for the Verlet mass-spring simulation array. It drives every core through whole simulation steps: one Verlet position-update pass, then a fixed number of constraint-relaxation passes, then a boundary-exchange handshake with all cores. It repeats this for a requested number of steps and signals completion. It sits above the per-core control units and supplies their phase enables and the node-slot walk.

## Interface
- WIDTH, 32: width of step counters.
- NODES, 5: nodes per core; length of one pass in cycles (≥2).
- CORES, 4: number of cores acknowledging the exchange.
- CNST_ITERS, 4: constraint passes per step (≥1).
- AW, $clog2(NODES): node address width.

- clk  in  1  clock.
- reset  in  1  synchronous, active-high.
- start  in  1  begin a run; sampled only in IDLE.
- num_steps  in  WIDTH  steps to run; latched on accepted start.
- pause  in  1  freeze request (see Configuration).
- exch_ack  in  CORES  per-core exchange-complete flags.
- busy  out  1  high in VERLET/CNST/EXCH.
- done  out  1  one-cycle pulse at run completion.
- phase  out  2  0=IDLE, 1=VERLET, 2=CNST, 3=EXCH.
- verlet_en  out  1  Verlet update enable.
- cnst_en  out  1  constraint update enable.
- exch_req  out  1  exchange request to all cores.
- node_onehot  out  NODES  active node slot, one-hot.
- node_addr  out  AW  active node index.
- cnst_iter  out  WIDTH  current constraint pass, 0-based.
- step_count  out  WIDTH  completed steps in the current or last run.

## Operation
- Reset: state IDLE. busy, done, verlet_en, cnst_en, and exch_req are 0. node_onehot, node_addr, cnst_iter, and step_count are 0.
- IDLE: all enables are 0, node_onehot is 0, and node_addr is 0.
  - On start with num_steps≠0: latch num_steps, clear step_count, go to VERLET with node_onehot=1 and node_addr=0.
  - On start with num_steps=0: stay in IDLE and pulse done next cycle.
- VERLET: verlet_en=1. node_onehot shifts left each cycle and node_addr increments. After slot NODES-1, go to CNST with node_onehot=1, node_addr=0, cnst_iter=0.
- CNST: cnst_en=1 with the same node walk.
  - At slot NODES-1 with cnst_iter<CNST_ITERS-1: wrap to slot 0 and increment cnst_iter.
  - At slot NODES-1 on the last pass: go to EXCH. node_onehot becomes 0 and cnst_iter becomes 0.
- EXCH: exch_req=1 and holds until &exch_ack is 1. On the accepting edge, step_count increments.
  - If the new step_count equals the latched num_steps: go to IDLE and assert done for one cycle.
  - Otherwise: go to VERLET at slot 0.
- start while busy is ignored. num_steps changes after latch have no effect.
- exch_req never drops before acceptance. A partial exch_ack never advances the state.
- Reset asserted mid-run returns everything to reset values on the next edge, with no done pulse.
- step_count wraps modulo 2^WIDTH and is not saturated.
- Only one of verlet_en, cnst_en, and exch_req may be high in any cycle.

## Timing
- All outputs are registered, except the pause masking of enables.
- start sampled at edge 0: first VERLET cycle is cycle 1.
- VERLET occupies NODES cycles. CNST occupies CNST_ITERS×NODES cycles.
- The first EXCH cycle is 1+NODES×(1+CNST_ITERS).
- With exch_ack held all-ones, EXCH lasts 1 cycle. One step is S=NODES×(1+CNST_ITERS)+1 cycles.
- done is high in cycle k×S+1 for a k-step run with immediate acks. busy falls in the same cycle.
- A new start is accepted in the done cycle, since the state is IDLE.

## Configuration
- SIM_SCHED_PAUSE_EN defined:
  - While pause=1, all registers hold, including state, node walk, counters, and latched num_steps.
  - verlet_en, cnst_en, and exch_req are forced to 0.
  - An ack arriving while paused is not accepted.
  - A done pulse already high clears normally.
  - start in IDLE while paused is ignored.
- SIM_SCHED_PAUSE_EN undefined: the pause port is present but ignored, and the scheduler never stalls except in EXCH.

## Test plan
All scenarios use NODES=5, CNST_ITERS=2, CORES=4, with exch_ack=4'hF unless noted.
- Reset: hold reset 3 cycles -> all outputs 0, phase=0.
- Single step: num_steps=1, start at cycle 0 ->
  - verlet_en cycles 1–5 with node_addr 0..4.
  - cnst_en cycles 6–15 with cnst_iter 0 then 1.
  - exch_req cycle 16.
  - done cycle 17, step_count=1.
- Multi-step with delayed ack:
  - Stimulus: num_steps=3; exch_ack=4'h7 for the first 3 EXCH cycles of each step, then 4'hF.
  - Response: each EXCH lasts 4 cycles; done at cycle 58; step_count=3; start pulses during the run are ignored.
- Zero steps: num_steps=0 -> done at cycle 1, no enable ever high, busy stays 0.
- Reset mid-run: reset at cycle 9 (CNST) -> next cycle all outputs are reset values, no done pulse; a new start runs a full step correctly.
- Pause (SIM_SCHED_PAUSE_EN defined): pause high cycles 3–6 -> enables low and node_addr frozen at 2; the walk resumes at 2 and done arrives 4 cycles late, at cycle 21.
